// File: rtl/fft_pkg.sv
// Shared definitions for the FFT_R2SDF pipeline stages.
// Holds the default component width, the complex sample type and the
// encoding of the rotator select that butterfly stages hand downstream.
package fft_pkg;

  // Default two's-complement width of one real or imaginary component.
  localparam int FFT_WIDTH = 37;

  // Complex sample at the default width.
  typedef struct packed {
    logic [FFT_WIDTH-1:0] re;
    logic [FFT_WIDTH-1:0] im;
  } cplx_t;

  // Rotator select: which twiddle the downstream trivial rotator applies.
  localparam logic W_ONE     = 1'b0;  // multiply by 1
  localparam logic W_MINUS_J = 1'b1;  // multiply by -j

endpackage

// File: rtl/sdf_delay_line.sv
// DEPTH-entry complex shift register forming the SDF feedback path.
// A new sample enters at the tail on every enabled cycle; the head is the
// sample written DEPTH enabled cycles earlier. Contents hold while disabled.
module sdf_delay_line #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_re_i,
  input  logic [WIDTH-1:0] din_im_i,
  output logic [WIDTH-1:0] head_re_o,
  output logic [WIDTH-1:0] head_im_o
);

  logic [WIDTH-1:0] re_q [DEPTH];
  logic [WIDTH-1:0] im_q [DEPTH];

  // Shift toward the head when enabled; clear every entry on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        re_q[i] <= '0;
        im_q[i] <= '0;
      end
    end else if (en_i) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        re_q[i] <= re_q[i+1];
        im_q[i] <= im_q[i+1];
      end
      re_q[DEPTH-1] <= din_re_i;
      im_q[DEPTH-1] <= din_im_i;
    end
  end

  assign head_re_o = re_q[0];
  assign head_im_o = im_q[0];

endmodule

// File: rtl/sdf_bf_stage.sv
// Radix-2 single-delay-feedback butterfly stage.
// First half of each 2*DEPTH frame: the input is parked in the delay line and
// the stored difference from the previous frame streams out. Second half:
// head + input goes out, head - input is written back for the next frame.
// Phi flags the fill-half outputs the downstream rotator multiplies by -j.
// Build option: define FFT_BF_SCALE_EN to halve butterfly sum/difference
// (computed one bit wider, arithmetic shift right by 1).
module sdf_bf_stage
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iValid,
  input  logic [WIDTH-1:0] iReal,
  input  logic [WIDTH-1:0] iImage,
  output logic             oValid,
  output logic [WIDTH-1:0] oReal,
  output logic [WIDTH-1:0] oImage,
  output logic             Phi
);

  localparam int            CW       = $clog2(2 * DEPTH);
  localparam logic [CW-1:0] LOW_MASK = CW'(DEPTH - 1);
  localparam logic [CW-1:0] PHI_LOW  = CW'(DEPTH / 2);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fill;
  logic [WIDTH-1:0] head_re, head_im;
  logic [WIDTH-1:0] sum_re, sum_im, dif_re, dif_im;
  logic [WIDTH-1:0] push_re, push_im;
  logic [WIDTH-1:0] out_re_d, out_im_d;
  logic             phi_d;
  logic             ovalid_q;
  logic [WIDTH-1:0] oreal_q, oimage_q;
  logic             phi_q;

  sdf_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_dly (
    .clk       (clk),
    .rst       (rst),
    .en_i      (iValid),
    .din_re_i  (push_re),
    .din_im_i  (push_im),
    .head_re_o (head_re),
    .head_im_o (head_im)
  );

`ifdef FFT_BF_SCALE_EN
  logic [WIDTH:0] sum_re_w, sum_im_w, dif_re_w, dif_im_w;

  // Butterfly one bit wider, then halve so the stage adds no growth.
  always_comb begin
    sum_re_w = {head_re[WIDTH-1], head_re} + {iReal[WIDTH-1], iReal};
    sum_im_w = {head_im[WIDTH-1], head_im} + {iImage[WIDTH-1], iImage};
    dif_re_w = {head_re[WIDTH-1], head_re} - {iReal[WIDTH-1], iReal};
    dif_im_w = {head_im[WIDTH-1], head_im} - {iImage[WIDTH-1], iImage};
    sum_re   = WIDTH'($signed(sum_re_w) >>> 1);
    sum_im   = WIDTH'($signed(sum_im_w) >>> 1);
    dif_re   = WIDTH'($signed(dif_re_w) >>> 1);
    dif_im   = WIDTH'($signed(dif_im_w) >>> 1);
  end
`else
  // Plain wrapping butterfly at WIDTH bits.
  always_comb begin
    sum_re = head_re + iReal;
    sum_im = head_im + iImage;
    dif_re = head_re - iReal;
    dif_im = head_im - iImage;
  end
`endif

  // Select fill or butterfly behaviour from the counter MSB.
  always_comb begin
    fill     = ~cnt_q[CW-1];
    cnt_d    = iValid ? cnt_q + CW'(1) : cnt_q;
    push_re  = dif_re;
    push_im  = dif_im;
    out_re_d = sum_re;
    out_im_d = sum_im;
    phi_d    = W_ONE;
    if (fill) begin
      push_re  = iReal;
      push_im  = iImage;
      out_re_d = head_re;
      out_im_d = head_im;
      phi_d    = ((cnt_q & LOW_MASK) >= PHI_LOW) ? W_MINUS_J : W_ONE;
    end
  end

  // Counter and output registers; data and Phi hold while iValid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      ovalid_q <= 1'b0;
      oreal_q  <= '0;
      oimage_q <= '0;
      phi_q    <= W_ONE;
    end else begin
      cnt_q    <= cnt_d;
      ovalid_q <= iValid;
      if (iValid) begin
        oreal_q  <= out_re_d;
        oimage_q <= out_im_d;
        phi_q    <= phi_d;
      end
    end
  end

  assign oValid = ovalid_q;
  assign oReal  = oreal_q;
  assign oImage = oimage_q;
  assign Phi    = phi_q;

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Bench for sdf_bf_stage (WIDTH=37, DEPTH=2): directed frames with literal
// expectations plus a randomized stream against a frame-level reference.
module tb_sdf_bf_stage;

  localparam int W = 37;
  localparam int D = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iValid = 1'b0;
  logic [W-1:0] iReal = '0;
  logic [W-1:0] iImage = '0;
  logic         oValid;
  logic [W-1:0] oReal, oImage;
  logic         Phi;

  int checks = 0;
  int errors = 0;

  sdf_bf_stage #(.WIDTH(W), .DEPTH(D)) dut (
    .clk    (clk),
    .rst    (rst),
    .iValid (iValid),
    .iReal  (iReal),
    .iImage (iImage),
    .oValid (oValid),
    .oReal  (oReal),
    .oImage (oImage),
    .Phi    (Phi)
  );

  // clock
  always #5 clk = ~clk;

  // ---------------- reference model (frame level) ----------------
  logic [W-1:0] first_re [D];
  logic [W-1:0] first_im [D];
  logic [W-1:0] diff_re  [D];
  logic [W-1:0] diff_im  [D];
  int           pos;
  logic         m_valid;
  logic [W-1:0] m_re, m_im;
  logic         m_phi;

  function automatic logic [W-1:0] bf_add(logic [W-1:0] a, logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
`ifdef FFT_BF_SCALE_EN
    return W'((sa + sb) >>> 1);
`else
    return W'(sa + sb);
`endif
  endfunction

  function automatic logic [W-1:0] bf_sub(logic [W-1:0] a, logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
`ifdef FFT_BF_SCALE_EN
    return W'((sa - sb) >>> 1);
`else
    return W'(sa - sb);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      first_re[i] = '0; first_im[i] = '0;
      diff_re[i]  = '0; diff_im[i]  = '0;
    end
    pos = 0; m_valid = 1'b0; m_re = '0; m_im = '0; m_phi = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [W-1:0] re, input logic [W-1:0] im);
    m_valid = v;
    if (v) begin
      if (pos < D) begin
        m_re = diff_re[pos];
        m_im = diff_im[pos];
        m_phi = (pos >= D / 2);
        first_re[pos] = re;
        first_im[pos] = im;
      end else begin
        m_re = bf_add(first_re[pos-D], re);
        m_im = bf_add(first_im[pos-D], im);
        diff_re[pos-D] = bf_sub(first_re[pos-D], re);
        diff_im[pos-D] = bf_sub(first_im[pos-D], im);
        m_phi = 1'b0;
      end
      pos = (pos + 1) % (2 * D);
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lit(input string tag, input longint er, input longint ei, input logic ep);
    chk({tag, "_re_lit"}, oReal, W'(er));
    chk({tag, "_im_lit"}, oImage, W'(ei));
    chk({tag, "_phi_lit"}, W'(Phi), W'(ep));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic v, input logic [W-1:0] re, input logic [W-1:0] im);
    @(negedge clk);
    iValid = v; iReal = re; iImage = im;
    model_step(v, re, im);
    @(posedge clk);
    #1;
    chk("valid", W'(oValid), W'(m_valid));
    chk("real", oReal, m_re);
    chk("imag", oImage, m_im);
    chk("phi", W'(Phi), W'(m_phi));
    @(negedge clk);
    iValid = 1'b0;
  endtask

  task automatic gap(input int n);
    for (int g = 0; g < n; g++) drive(1'b0, W'($urandom), W'($urandom));
  endtask

  // Reset with a valid sample present: reset must win.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; iValid = 1'b1; iReal = W'($urandom); iImage = W'($urandom);
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_valid", W'(oValid), '0);
    chk("rst_real", oReal, '0);
    chk("rst_imag", oImage, '0);
    chk("rst_phi", W'(Phi), '0);
    rst = 1'b0; iValid = 1'b0;
  endtask

  // Frame (1,0),(2,0),(3,0),(4,0) followed by a zero frame, literal checks.
  task automatic real_frame(input int max_gap);
    longint in_re [8] = '{1, 2, 3, 4, 0, 0, 0, 0};
`ifdef FFT_BF_SCALE_EN
    longint ex_re [8] = '{0, 0, 2, 3, -1, -1, 0, 0};
`else
    longint ex_re [8] = '{0, 0, 4, 6, -2, -2, 0, 0};
`endif
    logic   ex_ph [8] = '{0, 1, 0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      if (max_gap > 0) gap($urandom_range(max_gap, 1));
      drive(1'b1, W'(in_re[i]), '0);
      chk_lit($sformatf("rf%0d_%0d", max_gap, i), ex_re[i], 0, ex_ph[i]);
    end
  endtask

  initial begin : main
    logic [W-1:0] big;
    model_reset();
    // hold reset a few cycles
    repeat (3) @(posedge clk);
    do_reset();

    // basic real frame, continuous
    real_frame(0);

    // same frame with gaps between samples
    do_reset();
    real_frame(3);

    // imaginary path
    do_reset();
    drive(1'b1, '0, W'(1)); drive(1'b1, '0, W'(2));
    drive(1'b1, '0, W'(3));
`ifdef FFT_BF_SCALE_EN
    chk_lit("im_sum0", 0, 2, 0);
`else
    chk_lit("im_sum0", 0, 4, 0);
`endif
    drive(1'b1, '0, W'(4));
    drive(1'b1, '0, '0);
`ifdef FFT_BF_SCALE_EN
    chk_lit("im_dif0", 0, -1, 0);
`else
    chk_lit("im_dif0", 0, -2, 0);
`endif
    drive(1'b1, '0, '0);
`ifdef FFT_BF_SCALE_EN
    chk_lit("im_dif1", 0, -1, 1);
`else
    chk_lit("im_dif1", 0, -2, 1);
`endif
    drive(1'b1, '0, '0); drive(1'b1, '0, '0);

    // overflow: head = 2^36-1, input = 1
    do_reset();
    big = W'((64'd1 << 36) - 1);
    drive(1'b1, big, '0); drive(1'b1, '0, '0);
    drive(1'b1, W'(1), '0);
`ifdef FFT_BF_SCALE_EN
    chk_lit("ovf_sum", longint'(1) << 35, 0, 0);
`else
    chk_lit("ovf_sum", -(longint'(1) << 36), 0, 0);
`endif
    drive(1'b1, '0, '0);
    drive(1'b1, '0, '0);
`ifdef FFT_BF_SCALE_EN
    chk_lit("ovf_dif", (longint'(1) << 35) - 1, 0, 0);
`else
    chk_lit("ovf_dif", (longint'(1) << 36) - 2, 0, 0);
`endif
    drive(1'b1, '0, '0); drive(1'b1, '0, '0); drive(1'b1, '0, '0);

    // reset mid-frame at cnt = 2, then first-frame behaviour again
    do_reset();
    drive(1'b1, W'(7), W'(9)); drive(1'b1, W'(5), W'(3));
    do_reset();
    real_frame(0);

    // randomized stream, 64 frames, occasional gaps
    do_reset();
    for (int f = 0; f < 64; f++) begin
      for (int s = 0; s < 2 * D; s++) begin
        if ($urandom_range(3, 0) == 0) gap($urandom_range(3, 1));
        if ($urandom_range(1, 0) == 0)
          drive(1'b1, W'({$urandom, $urandom}), W'({$urandom, $urandom}));
        else
          drive(1'b1, W'($urandom_range(200, 0) - 100), W'($urandom_range(200, 0) - 100));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
